// File: rtl/des_engine_arbiter.sv
// Round-robin front end that time-shares one DES core among NUM_REQ requesters.
// Sequences the core's setup/start/ready handshake and aborts hung operations.
module des_engine_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [64*NUM_REQ-1:0]   req_data,
    input  logic [64*NUM_REQ-1:0]   req_key,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [63:0]             rsp_data,
    output logic                    rsp_err,
    output logic                    core_start,
    output logic [63:0]             core_din,
    output logic [63:0]             core_key,
    input  logic                    core_ready,
    input  logic [63:0]             core_dout,
    output logic                    busy
);

    localparam int IDW    = $clog2(NUM_REQ);
    localparam int PH_MAX = (SETUP_CYCLES > START_CYCLES) ? SETUP_CYCLES : START_CYCLES;
    localparam int PHW    = $clog2(PH_MAX + 1);
    localparam int TOW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_START, S_WAIT_CLR, S_WAIT_DONE, S_RESP
    } state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr, gid, gnt_id, idx;
    logic             gnt_found, hs;
    logic [63:0]      sel_data, sel_key, din_q, key_q;
    logic [PHW-1:0]   ph_cnt;
    logic [TOW-1:0]   to_cnt;
    logic             setup_last, start_last, to_hit;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NUM_REQ);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_key  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_data = req_data[i*64 +: 64];
                sel_key  = req_key[i*64 +: 64];
            end
        end
    end

    assign hs         = (state == S_IDLE) && gnt_found;
    assign setup_last = (ph_cnt == PHW'(SETUP_CYCLES - 1));
    assign start_last = (ph_cnt == PHW'(START_CYCLES - 1));
    assign to_hit     = (to_cnt == TOW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Completion is checked ahead of the timeout so a same-cycle ready wins.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (hs) state_nxt = S_SETUP;
            S_SETUP:     if (setup_last) state_nxt = S_START;
            S_START:     if (start_last) state_nxt = S_WAIT_CLR;
            S_WAIT_CLR:  if (to_hit) state_nxt = S_RESP;
                         else if (!core_ready) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (core_ready || to_hit) state_nxt = S_RESP;
            S_RESP:      if (rsp_ready[gid]) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        core_start = (state == S_START);
        busy       = (state != S_IDLE);
        if (hs) req_ready[gnt_id] = 1'b1;
        if (state == S_RESP) rsp_valid[gid] = 1'b1;
    end

    assign core_din = din_q;
    assign core_key = key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            gid      <= '0;
            din_q    <= '0;
            key_q    <= '0;
            ph_cnt   <= '0;
            to_cnt   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (hs) begin
                    din_q  <= sel_data;
                    key_q  <= sel_key;
                    gid    <= gnt_id;
                    ptr    <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
                    ph_cnt <= '0;
                end
                S_SETUP: ph_cnt <= setup_last ? '0 : ph_cnt + 1'b1;
                S_START: begin
                    ph_cnt <= start_last ? '0 : ph_cnt + 1'b1;
                    to_cnt <= '0;
                end
                S_WAIT_CLR, S_WAIT_DONE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (state == S_WAIT_DONE && core_ready) begin
                        rsp_data <= core_dout;
                        rsp_err  <= 1'b0;
                    end else if (to_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                S_RESP: if (rsp_ready[gid]) rsp_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_engine_arbiter.sv
// Directed bench for des_engine_arbiter: behavioural DES core model plus an
// in-order response scoreboard fed at stimulus time.
module tb_des_engine_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [64*N-1:0]  req_data, req_key;
    logic [63:0]      rsp_data, core_din, core_key;
    logic             rsp_err, core_start, busy;
    logic             core_ready = 1'b1;
    logic [63:0]      core_dout  = '0;

    des_engine_arbiter #(.NUM_REQ(N), .SETUP_CYCLES(2), .START_CYCLES(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_start(core_start), .core_din(core_din), .core_key(core_key),
        .core_ready(core_ready), .core_dout(core_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference DES ----------------
    localparam int IP_T[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T[48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T[32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                 19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SH_T[16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam logic [2047:0] SBOX = {
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic logic [63:0] des(input logic [63:0] pt, input logic [63:0] key);
        logic [55:0] k56, cd;
        logic [27:0] c, d;
        logic [63:0] x, rl, o;
        logic [31:0] l, r, f4, f, t;
        logic [47:0] e, k48;
        logic [5:0]  six;
        int          ix;
        for (int i = 0; i < 56; i++) k56[55-i] = key[64-PC1_T[i]];
        c = k56[55:28];
        d = k56[27:0];
        for (int i = 0; i < 64; i++) x[63-i] = pt[64-IP_T[i]];
        l = x[63:32];
        r = x[31:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            for (int s = 0; s < SH_T[rnd]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) k48[47-i] = cd[56-PC2_T[i]];
            for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
            e = e ^ k48;
            for (int b = 0; b < 8; b++) begin
                six = e[47-6*b -: 6];
                ix  = b*64 + {six[5], six[0]}*16 + six[4:1];
                f4[31-4*b -: 4] = SBOX[2047-4*ix -: 4];
            end
            for (int i = 0; i < 32; i++) f[31-i] = f4[32-P_T[i]];
            t = l ^ f;
            l = r;
            r = t;
        end
        rl = {r, l};
        for (int i = 0; i < 64; i++) o[63-i] = rl[64-FP_T[i]];
        return o;
    endfunction

    // ---------------- core model ----------------
    int          clr_delay = 1, core_lat = 3;
    logic        hang = 1'b0;
    logic        start_q = 1'b0, busy_m = 1'b0;
    int          clr_cnt = 0, lat_cnt = 0;
    logic [63:0] res = '0;

    always @(posedge clk) begin
        start_q <= core_start;
        if (core_start && !start_q) begin
            busy_m  <= 1'b1;
            clr_cnt <= clr_delay;
            lat_cnt <= core_lat;
            res     <= des(core_din, core_key);
        end else if (busy_m) begin
            if (clr_cnt > 0) begin
                clr_cnt <= clr_cnt - 1;
                if (clr_cnt == 1) begin
                    core_ready <= 1'b0;
                    if (hang) busy_m <= 1'b0;
                end
            end else if (lat_cnt > 0) begin
                lat_cnt <= lat_cnt - 1;
            end else begin
                core_ready <= 1'b1;
                core_dout  <= res;
                busy_m     <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    typedef struct { int id; logic [63:0] data; logic err; } exp_t;
    exp_t sb[$];
    exp_t ent;
    int   checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input logic [63:0] data, input logic err);
        exp_t x;
        x.id = id; x.data = data; x.err = err;
        return x;
    endfunction

    int          setup_cnt = 0, width_cnt = 0, wait_cnt = 0;
    logic        busy_q = 1'b0, din_stable = 1'b0;
    logic [63:0] din_ref = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_q = 1'b0;
        end else begin
            if (busy && !busy_q) begin
                setup_cnt = 1; width_cnt = 0; wait_cnt = 0;
                din_ref = core_din; din_stable = 1'b1;
            end else if (busy) begin
                if (core_din !== din_ref) din_stable = 1'b0;
                if (core_start) width_cnt++;
                else if (width_cnt == 0) setup_cnt++;
                else if (rsp_valid == '0) wait_cnt++;
            end
            busy_q = busy;
            for (int k = 0; k < N; k++) begin
                if (rsp_valid[k] && rsp_ready[k]) begin
                    chk("rsp_onehot", $countones(rsp_valid), 1);
                    chk("sb_has_entry", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        ent = sb.pop_front();
                        chk("rsp_id", k, ent.id);
                        chk("rsp_data", rsp_data, ent.data);
                        chk("rsp_err", rsp_err, ent.err);
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [63:0] pt, input logic [63:0] key);
        bit done = 1'b0;
        @(posedge clk); #1;
        req_data[k*64 +: 64] = pt;
        req_key[k*64 +: 64]  = key;
        req_valid[k] = 1'b1;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            if (req_ready[k]) done = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        chk($sformatf("req%0d_accepted", k), done, 1);
    endtask

    task automatic drain(input int lim);
        int c = 0;
        while (sb.size() > 0 && c < lim) begin
            @(negedge clk);
            c++;
        end
        chk("drain_done", sb.size(), 0);
        sb.delete();
    endtask

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    logic [63:0] pt_f[5];
    logic [63:0] bp_exp;
    bit          seen;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_key = '0; rsp_ready = '1;
        repeat (3) @(posedge clk); #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_din", core_din, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_busy", busy, 0);
        chk("des_kat", des(PT, KEY), 64'h85E813540F0AB405);

        // pointer starts at 0; withdrawn request produces no grant
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b1100; #1;
        chk("ptr0_from_2", req_ready, 4'b0100);
        req_valid = 4'b1111; #1;
        chk("ptr0_all", req_ready, 4'b0001);
        req_valid = '0;
        @(posedge clk); @(negedge clk);
        chk("drop_no_busy", busy, 0);

        // fairness: all four contend, requester 0 asks twice
        for (int i = 0; i < 5; i++) pt_f[i] = 64'h1111_0000_0000_0000 * (i + 1) + 64'(i * 7 + 3);
        for (int i = 0; i < 5; i++) sb.push_back(mk(i % N, des(pt_f[i], KEY), 1'b0));
        fork
            begin send(0, pt_f[0], KEY); send(0, pt_f[4], KEY); end
            send(1, pt_f[1], KEY);
            send(2, pt_f[2], KEY);
            send(3, pt_f[3], KEY);
        join
        drain(400);

        // single known-answer request with start-pulse shape
        sb.push_back(mk(0, 64'h85E813540F0AB405, 1'b0));
        send(0, PT, KEY);
        drain(200);
        chk("setup_cycles", setup_cnt, 2);
        chk("start_width", width_cnt, 2);
        chk("din_stable", din_stable, 1);
        chk("din_value", din_ref, PT);

        // response backpressure on requester 2 while 1 and 3 wait
        rsp_ready = 4'b1011;
        bp_exp = des(64'hA5A5_5A5A_0F0F_F0F0, KEY);
        sb.push_back(mk(2, bp_exp, 1'b0));
        sb.push_back(mk(3, des(64'h3333_3333_3333_3333, KEY), 1'b0));
        sb.push_back(mk(1, des(64'h1111_1111_1111_1111, KEY), 1'b0));
        send(2, 64'hA5A5_5A5A_0F0F_F0F0, KEY);
        fork
            send(1, 64'h1111_1111_1111_1111, KEY);
            send(3, 64'h3333_3333_3333_3333, KEY);
        join_none
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid[2]) seen = 1'b1;
        end
        chk("bp_rsp_seen", seen, 1);
        repeat (20) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 4'b0100);
            chk("bp_data", rsp_data, bp_exp);
            chk("bp_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = '1;
        drain(400);
        wait fork;

        // stale ready: core clears ready 3 cycles after start
        clr_delay = 3;
        sb.push_back(mk(1, des(64'hDEAD_BEEF_0BAD_F00D, KEY), 1'b0));
        send(1, 64'hDEAD_BEEF_0BAD_F00D, KEY);
        drain(200);
        clr_delay = 1;

        // completion on the very last cycle before timeout
        core_lat = 14;
        sb.push_back(mk(2, des(64'h0F1E_2D3C_4B5A_6978, KEY), 1'b0));
        send(2, 64'h0F1E_2D3C_4B5A_6978, KEY);
        drain(200);
        chk("edge_wait_cycles", wait_cnt, TO);
        core_lat = 3;

        // hung core: timeout response, then a normal one
        hang = 1'b1;
        sb.push_back(mk(3, 64'h0, 1'b1));
        send(3, 64'hFEDC_BA98_7654_3210, KEY);
        drain(200);
        chk("to_wait_cycles", wait_cnt, TO);
        hang = 1'b0;
        sb.push_back(mk(0, des(64'h0123_0123_0123_0123, KEY), 1'b0));
        send(0, 64'h0123_0123_0123_0123, KEY);
        drain(200);

        // reset while waiting on the core
        core_lat = 10;
        send(1, 64'h5555_AAAA_5555_AAAA, KEY);
        repeat (8) @(posedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_core_start", core_start, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'b1111; #1;
        chk("mid_rst_ptr0", req_ready, 4'b0001);
        req_valid = '0;
        repeat (30) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
